// File: rtl/power_window_accumulator.sv
// Resolves the CSA tree's carry-save pair, accumulates 2**WIN_LOG2 samples per window.
// Build option: PWR_ACC_AVG_EN selects window mean instead of raw window sum on pwr_out.
module power_window_accumulator #(
  parameter int MAX      = 36,
  parameter int WIN_LOG2 = 8,
  parameter int TREE_LAT = 3,
  localparam int ACC_W   = MAX + WIN_LOG2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic [MAX-1:0]   vs,
  input  logic [MAX-1:0]   vc,
  output logic [MAX-1:0]   smp_out,
  output logic             smp_valid,
  output logic [ACC_W-1:0] pwr_out,
  output logic             pwr_valid,
  output logic [WIN_LOG2-1:0] win_cnt
);

  localparam int H  = MAX / 2;
  localparam int HW = MAX - H;
  localparam int FW = (TREE_LAT > 0) ? $clog2(TREE_LAT + 1) : 1;
  localparam logic [FW-1:0]       FILL_MAX = FW'(TREE_LAT);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

  logic [FW-1:0]       fill_cnt_q, fill_cnt_d;
  logic                va_q, va_d;
  logic [H-1:0]        lo_q, lo_d;
  logic                cy_q, cy_d;
  logic [HW-1:0]       hs_q, hs_d, hc_q, hc_d;
  logic [MAX-1:0]      smp_out_q, smp_out_d;
  logic                smp_valid_q, smp_valid_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    pwr_out_q, pwr_out_d;
  logic                pwr_valid_q, pwr_valid_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;

  logic                in_v_s;
  logic [H:0]          lo_sum_s;
  logic [ACC_W-1:0]    win_sum_s;
  logic [ACC_W-1:0]    pwr_res_s;

  // Next-state logic: fill gating, two-stage adder, window accumulation.
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    va_d        = va_q;
    smp_valid_d = smp_valid_q;
    acc_d       = acc_q;
    pwr_out_d   = pwr_out_q;
    pwr_valid_d = 1'b0;
    win_cnt_d   = win_cnt_q;

    in_v_s    = en & (fill_cnt_q == FILL_MAX);
    lo_sum_s  = {1'b0, vs[H-1:0]} + {1'b0, vc[H-1:0]};
    win_sum_s = acc_q + {{WIN_LOG2{smp_out_q[MAX-1]}}, smp_out_q};
`ifdef PWR_ACC_AVG_EN
    pwr_res_s = $signed(win_sum_s) >>> WIN_LOG2;
`else
    pwr_res_s = win_sum_s;
`endif

    // Data registers run freely; only the valid bits carry meaning.
    lo_d      = lo_sum_s[H-1:0];
    cy_d      = lo_sum_s[H];
    hs_d      = vs[MAX-1:H];
    hc_d      = vc[MAX-1:H];
    smp_out_d = {hs_q + hc_q + HW'(cy_q), lo_q};

    if (clear) begin
      fill_cnt_d  = '0;
      va_d        = 1'b0;
      smp_valid_d = 1'b0;
      acc_d       = '0;
      win_cnt_d   = '0;
      pwr_valid_d = 1'b0;
      smp_out_d   = smp_out_q;
    end else begin
      if (en && (fill_cnt_q != FILL_MAX)) begin
        fill_cnt_d = fill_cnt_q + FW'(1'b1);
      end else begin
        fill_cnt_d = fill_cnt_q;
      end
      va_d        = in_v_s;
      smp_valid_d = va_q;
      if (smp_valid_q) begin
        if (win_cnt_q == WIN_LAST) begin
          pwr_out_d   = pwr_res_s;
          pwr_valid_d = 1'b1;
          acc_d       = '0;
          win_cnt_d   = '0;
        end else begin
          acc_d     = win_sum_s;
          win_cnt_d = win_cnt_q + WIN_LOG2'(1'b1);
        end
      end else begin
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt_q  <= '0;
      va_q        <= 1'b0;
      lo_q        <= '0;
      cy_q        <= 1'b0;
      hs_q        <= '0;
      hc_q        <= '0;
      smp_out_q   <= '0;
      smp_valid_q <= 1'b0;
      acc_q       <= '0;
      pwr_out_q   <= '0;
      pwr_valid_q <= 1'b0;
      win_cnt_q   <= '0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      va_q        <= va_d;
      lo_q        <= lo_d;
      cy_q        <= cy_d;
      hs_q        <= hs_d;
      hc_q        <= hc_d;
      smp_out_q   <= smp_out_d;
      smp_valid_q <= smp_valid_d;
      acc_q       <= acc_d;
      pwr_out_q   <= pwr_out_d;
      pwr_valid_q <= pwr_valid_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign smp_out   = smp_out_q;
  assign smp_valid = smp_valid_q;
  assign pwr_out   = pwr_out_q;
  assign pwr_valid = pwr_valid_q;
  assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_power_window_accumulator.sv
// Self-checking bench for power_window_accumulator (WIN_LOG2=2, TREE_LAT=3, MAX=36).
// Scoreboard queues hold expected samples/window results; a negedge monitor compares them.
module tb_power_window_accumulator;
  localparam int MAX = 36;
  localparam int WL  = 2;
  localparam int TL  = 3;
  localparam int AW  = MAX + WL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          clear = 1'b0;
  logic [MAX-1:0] vs = '0;
  logic [MAX-1:0] vc = '0;
  logic [MAX-1:0] smp_out;
  logic          smp_valid;
  logic [AW-1:0] pwr_out;
  logic          pwr_valid;
  logic [WL-1:0] win_cnt;

  power_window_accumulator #(.MAX(MAX), .WIN_LOG2(WL), .TREE_LAT(TL)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .vs(vs), .vc(vc),
    .smp_out(smp_out), .smp_valid(smp_valid), .pwr_out(pwr_out),
    .pwr_valid(pwr_valid), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [MAX-1:0] vs;
    logic [MAX-1:0] vc;
    logic [MAX-1:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int pwr_seen = 0;
  int fill = 0;
  int wcnt = 0;
  logic [AW-1:0]  wsum = '0;
  logic [MAX-1:0] smp_q[$];
  logic [AW-1:0]  pwr_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] pwr_of(input logic [AW-1:0] s);
`ifdef PWR_ACC_AVG_EN
    return $signed(s) >>> WL;
`else
    return s;
`endif
  endfunction

  task automatic flush();
    smp_q.delete();
    pwr_q.delete();
    fill = 0;
    wcnt = 0;
    wsum = '0;
  endtask

  // Drive one cycle and predict what the DUT should produce from it.
  task automatic step(input logic e, input logic c, input logic [MAX-1:0] a,
                      input logic [MAX-1:0] b, input logic [MAX-1:0] exp);
    en = e; clear = c; vs = a; vc = b;
    if (!c && e) begin
      if (fill == TL) begin
        smp_q.push_back(exp);
        wsum = wsum + {{WL{exp[MAX-1]}}, exp};
        if (wcnt == 3) begin
          pwr_q.push_back(pwr_of(wsum));
          wsum = '0;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        fill++;
      end
    end
    @(posedge clk); #1;
    if (c) flush();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic run_s1();
    int p0;
    p0 = pwr_seen;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 36'd5, 36'd3, 36'd8);
      if (i == 3) chk("s1_lat_before", smp_valid, 1'b0);
      if (i == 4) chk("s1_lat_first", smp_valid, 1'b1);
    end
    idle(3);
    chk("s1_windows", pwr_seen - p0, 3);
    chk("s1_win_cnt", win_cnt, 2'd0);
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (smp_valid) begin
        if (smp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL smp_unexpected: got %h expected no sample", smp_out);
        end else begin
          chk("smp_out", smp_out, smp_q.pop_front());
        end
      end
      if (pwr_valid) begin
        pwr_seen++;
        if (pwr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pwr_unexpected: got %h expected no window", pwr_out);
        end else begin
          chk("pwr_out", pwr_out, pwr_q.pop_front());
        end
      end
    end
  end

  initial begin
    vec_t tbl[9];
    logic [AW-1:0] e3, e5;
    int p0;

    tbl[0] = '{1'b1, 36'hF_FFFF_FFFF, 36'h0_0000_0001, 36'h0_0000_0000};
    tbl[1] = '{1'b1, 36'h8_0000_0000, 36'h0_0000_0000, 36'h8_0000_0000};
    tbl[2] = '{1'b0, 36'h0_0000_1234, 36'h0_0000_1234, 36'h0_0000_0000};
    tbl[3] = '{1'b1, 36'h0_0003_FFFF, 36'h0_0000_0001, 36'h0_0004_0000};
    tbl[4] = '{1'b1, 36'h7_FFFF_FFFF, 36'h0_0000_0000, 36'h7_FFFF_FFFF};
    tbl[5] = '{1'b1, 36'hF_FFFF_FFFD, 36'h0_0000_0000, 36'hF_FFFF_FFFD};
    tbl[6] = '{1'b1, 36'hF_FFFF_FFFE, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFD};
    tbl[7] = '{1'b1, 36'h0_0000_0000, 36'hF_FFFF_FFFD, 36'hF_FFFF_FFFD};
    tbl[8] = '{1'b1, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFE};
`ifdef PWR_ACC_AVG_EN
    e3 = 38'h3F_FFFF_FFFD;
    e5 = 38'h00_0000_0003;
`else
    e3 = 38'h3F_FFFF_FFF5;
    e5 = 38'h00_0000_000C;
`endif

    #2;
    chk("rst_smp_out", smp_out, 36'd0);
    chk("rst_smp_valid", smp_valid, 1'b0);
    chk("rst_pwr_out", pwr_out, 38'd0);
    chk("rst_pwr_valid", pwr_valid, 1'b0);
    chk("rst_win_cnt", win_cnt, 2'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_s1();

    p0 = pwr_seen;
    for (int i = 0; i < 9; i++) step(tbl[i].en, 1'b0, tbl[i].vs, tbl[i].vc, tbl[i].exp);
    idle(3);
    chk("tbl_windows", pwr_seen - p0, 2);
    chk("neg_window_pwr", pwr_out, e3);
    chk("tbl_win_cnt", win_cnt, 2'd0);

    p0 = pwr_seen;
    step(1'b1, 1'b0, 36'd1, 36'd1, 36'd2);
    step(1'b0, 1'b0, 36'd1, 36'd1, 36'd2);
    step(1'b1, 1'b0, 36'd1, 36'd1, 36'd2);
    step(1'b0, 1'b0, 36'd1, 36'd1, 36'd2);
    idle(3);
    chk("gap_win_cnt_mid", win_cnt, 2'd2);
    chk("gap_no_pwr_yet", pwr_seen - p0, 0);
    step(1'b1, 1'b0, 36'd1, 36'd1, 36'd2);
    step(1'b0, 1'b0, 36'd1, 36'd1, 36'd2);
    step(1'b1, 1'b0, 36'd1, 36'd1, 36'd2);
    idle(3);
    chk("gap_pwr_after_4", pwr_seen - p0, 1);
    chk("gap_win_cnt_end", win_cnt, 2'd0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 36'd7, 36'd0, 36'd7);
    chk("clr_pre_win_cnt", win_cnt, 2'd3);
    chk("clr_pre_inflight", smp_valid, 1'b1);
    p0 = pwr_seen;
    step(1'b0, 1'b1, '0, '0, '0);
    chk("clr_win_cnt", win_cnt, 2'd0);
    chk("clr_smp_valid", smp_valid, 1'b0);
    chk("clr_pwr_valid", pwr_valid, 1'b0);
    chk("clr_smp_out_hold", smp_out, 36'd7);
    idle(3);
    chk("clr_no_pwr", pwr_seen - p0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 36'd100, 36'd0, 36'd100);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 36'd3, 36'd0, 36'd3);
    idle(3);
    chk("clr_post_windows", pwr_seen - p0, 1);
    chk("clr_post_pwr", pwr_out, e5);

    step(1'b1, 1'b0, 36'd5, 36'd3, 36'd8);
    step(1'b1, 1'b0, 36'd5, 36'd3, 36'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_smp_out", smp_out, 36'd0);
    chk("arst_smp_valid", smp_valid, 1'b0);
    chk("arst_pwr_out", pwr_out, 38'd0);
    chk("arst_pwr_valid", pwr_valid, 1'b0);
    chk("arst_win_cnt", win_cnt, 2'd0);
    flush();
    en = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    run_s1();

    chk("smp_queue_drained", smp_q.size(), 0);
    chk("pwr_queue_drained", pwr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
